// File: rtl/fsk_bit_decoder.sv
// FSK bit decoder: turns per-window increments of two cumulative tone counters
// into bits, frames them UART-style and presents each word on a valid/ready buffer.
module fsk_bit_decoder #(
  parameter int unsigned BIT_TICKS = 41667,
  parameter int unsigned MIN_TICKS = 20833,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [31:0]          f0_value,
  input  logic [31:0]          f1_value,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_error,
  output logic                 overrun,
  output logic                 bit_strobe,
  output logic                 bit_value
);

  localparam int unsigned CW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] WIN_LAST = CW'(BIT_TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [31:0]   MIN_D    = 32'(MIN_TICKS);

  typedef enum logic [1:0] {ARM, HUNT, DATA, STOP} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          win_cnt_q, win_cnt_d;
  logic [31:0]            prev0_q, prev0_d, prev1_q, prev1_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
  logic                   strobe_q, strobe_d;
  logic                   bitv_q, bitv_d;

  logic                   win_end_c;
  logic [31:0]            d0_c, d1_c;
  logic                   is_one_c, is_zero_c;
  logic                   word_done_c;

  // Modulo-2^32 deltas handle analyzer counter wrap for free.
  assign win_end_c = enable && (win_cnt_q == WIN_LAST);
  assign d0_c      = f0_value - prev0_q;
  assign d1_c      = f1_value - prev1_q;
  assign is_one_c  = (d1_c > d0_c) && (d1_c >= MIN_D);
  assign is_zero_c = (d0_c > d1_c) && (d0_c >= MIN_D);

  // Window timer, framing FSM and output buffer next-state logic.
  always_comb begin
    state_d     = state_q;
    win_cnt_d   = win_cnt_q;
    prev0_d     = prev0_q;
    prev1_d     = prev1_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    data_d      = data_q;
    valid_d     = valid_q;
    ferr_d      = 1'b0;
    ovr_d       = 1'b0;
    strobe_d    = 1'b0;
    bitv_d      = 1'b0;
    word_done_c = 1'b0;

    if (!enable) begin
      win_cnt_d = '0;
      prev0_d   = f0_value;
      prev1_d   = f1_value;
      state_d   = ARM;
    end else begin
      win_cnt_d = win_end_c ? '0 : win_cnt_q + CW'(1);
      if (win_end_c) begin
        prev0_d  = f0_value;
        prev1_d  = f1_value;
        strobe_d = 1'b1;
        bitv_d   = is_one_c;
        case (state_q)
          ARM: begin
            if (is_one_c) state_d = HUNT;
          end
          HUNT: begin
            if (is_zero_c) begin
              state_d   = DATA;
              bit_cnt_d = '0;
            end else if (!is_one_c) begin
              state_d = ARM;
            end
          end
          DATA: begin
            if (is_one_c || is_zero_c) begin
              for (int i = 0; i < int'(DATA_BITS); i++) begin
                if (bit_cnt_q == BW'(i)) shift_d[i] = is_one_c;
              end
              if (bit_cnt_q == BIT_LAST) state_d = STOP;
              else bit_cnt_d = bit_cnt_q + BW'(1);
            end else begin
              ferr_d  = 1'b1;
              state_d = ARM;
            end
          end
          STOP: begin
            if (is_one_c) begin
              word_done_c = 1'b1;
              state_d     = HUNT;
            end else begin
              ferr_d  = 1'b1;
              state_d = ARM;
            end
          end
          default: state_d = ARM;
        endcase
      end
    end

    // A full buffer can still take a new word if the old one leaves this edge.
    if (word_done_c && (!valid_q || data_ready)) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end else if (word_done_c) begin
      ovr_d = 1'b1;
    end else if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ARM;
      win_cnt_q <= '0;
      prev0_q   <= '0;
      prev1_q   <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      strobe_q  <= 1'b0;
      bitv_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      prev0_q   <= prev0_d;
      prev1_q   <= prev1_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      strobe_q  <= strobe_d;
      bitv_q    <= bitv_d;
    end
  end

  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign frame_error = ferr_q;
  assign overrun     = ovr_q;
  assign bit_strobe  = strobe_q;
  assign bit_value   = bitv_q;

endmodule
